// File: rtl/mac_kbd_sequencer.sv
// mac_kbd_sequencer: keyboard transaction sequencer for the VIA shift register.
// Latches the command byte the host shifts out and decodes it. It then
// schedules the reply (queued key, null 8'h7B, model ID or ACK 8'h7D) and
// returns it as an SR load strobe after a delay that models the keyboard
// clocking 8 bits.
// Build option: define KBD_SEQ_FIFO_EN for a FIFO_DEPTH-entry key queue.
// Without it, a single holding register buffers one key.
module mac_kbd_sequencer #(
    parameter int         RESP_DELAY  = 16,
    parameter int         INQ_TIMEOUT = 196000,
    parameter logic [7:0] MODEL_ID    = 8'h0B,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cen,
    input  logic [7:0] cmd_data,
    input  logic       cmd_strobe,
    output logic [7:0] resp_data,
    output logic       resp_strobe,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       busy,
    output logic       cmd_drop
);

    localparam int TW = $clog2(INQ_TIMEOUT + 1);
    localparam int DW = $clog2(RESP_DELAY + 1);

    localparam logic [7:0] CMD_INQUIRY = 8'h10;
    localparam logic [7:0] CMD_INSTANT = 8'h14;
    localparam logic [7:0] CMD_MODEL   = 8'h16;
    localparam logic [7:0] CMD_TEST    = 8'h36;
    localparam logic [7:0] RESP_NULL   = 8'h7B;
    localparam logic [7:0] RESP_ACK    = 8'h7D;

    typedef enum logic [2:0] {IDLE, DECODE, WAIT_KEY, DELAY, STROBE} stateT;

    stateT          state, stateNext;
    logic [7:0]     cmdReg;
    logic [TW-1:0]  timer;
    logic [DW-1:0]  delayCnt;
    logic [7:0]     respData, respNext;
    logic           respLoad;
    logic           queuePush, queuePop, queueFlush, queueEmpty;
    logic [7:0]     queueHead;

    assign queuePush = key_valid && key_ready;

    // State, command latch, counters and reply register; counters restart on every state entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cmdReg   <= 8'h00;
            timer    <= '0;
            delayCnt <= '0;
            respData <= 8'h00;
        end else if (cen) begin
            state <= stateNext;
            if (state == IDLE && cmd_strobe)
                cmdReg <= cmd_data;
            timer    <= (state == WAIT_KEY && stateNext == WAIT_KEY) ? timer + 1'b1 : '0;
            delayCnt <= (state == DELAY && stateNext == DELAY) ? delayCnt + 1'b1 : '0;
            if (respLoad)
                respData <= respNext;
        end
    end

    // Next state, reply selection and queue pop/flush requests
    always_comb begin
        stateNext  = state;
        respLoad   = 1'b0;
        respNext   = respData;
        queuePop   = 1'b0;
        queueFlush = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_strobe)
                    stateNext = DECODE;
            end
            DECODE: begin
                case (cmdReg)
                    CMD_INQUIRY: stateNext = WAIT_KEY;
                    CMD_INSTANT: begin
                        respLoad  = 1'b1;
                        stateNext = DELAY;
                        if (!queueEmpty) begin
                            respNext = queueHead;
                            queuePop = 1'b1;
                        end else begin
                            respNext = RESP_NULL;
                        end
                    end
                    CMD_MODEL: begin
                        respLoad   = 1'b1;
                        respNext   = MODEL_ID;
                        queueFlush = 1'b1;
                        stateNext  = DELAY;
                    end
                    CMD_TEST: begin
                        respLoad  = 1'b1;
                        respNext  = RESP_ACK;
                        stateNext = DELAY;
                    end
                    default: stateNext = IDLE;
                endcase
            end
            WAIT_KEY: begin
                // A key arriving on the timeout cycle takes priority over the null reply
                if (!queueEmpty) begin
                    respLoad  = 1'b1;
                    respNext  = queueHead;
                    queuePop  = 1'b1;
                    stateNext = DELAY;
                end else if (timer == TW'(INQ_TIMEOUT - 1)) begin
                    respLoad  = 1'b1;
                    respNext  = RESP_NULL;
                    stateNext = DELAY;
                end
            end
            DELAY: begin
                if (delayCnt == DW'(RESP_DELAY - 1))
                    stateNext = STROBE;
            end
            STROBE:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Status outputs decoded from state; strobes stretch over cen=0 clocks
    always_comb begin
        busy        = (state != IDLE);
        resp_strobe = (state == STROBE);
        cmd_drop    = cmd_strobe && (state != IDLE);
        resp_data   = respData;
    end

`ifdef KBD_SEQ_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rdPtr, wrPtr;
    logic [AW:0]   count;

    assign queueEmpty = (count == '0);
    assign key_ready  = (count != (AW + 1)'(FIFO_DEPTH));
    assign queueHead  = mem[rdPtr];

    // Queue pointers and occupancy; a flush wins over a simultaneous push
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (cen) begin
            if (queueFlush) begin
                rdPtr <= '0;
                wrPtr <= '0;
                count <= '0;
            end else begin
                if (queuePush) wrPtr <= wrPtr + 1'b1;
                if (queuePop)  rdPtr <= rdPtr + 1'b1;
                if (queuePush && !queuePop)      count <= count + 1'b1;
                else if (!queuePush && queuePop) count <= count - 1'b1;
            end
        end
    end

    // Queue storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (cen && queuePush)
            mem[wrPtr] <= key_code;
    end
`else
    logic [7:0] holdReg;
    logic       holdValid;
    // FIFO_DEPTH has no meaning for the single-register buffer
    logic       unusedDepth;
    assign unusedDepth = ^32'(FIFO_DEPTH);

    assign queueEmpty = !holdValid;
    assign key_ready  = !holdValid;
    assign queueHead  = holdReg;

    // Single-key holding register; a flush wins over a simultaneous push
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            holdReg   <= 8'h00;
            holdValid <= 1'b0;
        end else if (cen) begin
            if (queueFlush) begin
                holdValid <= 1'b0;
            end else if (queuePush) begin
                holdReg   <= key_code;
                holdValid <= 1'b1;
            end else if (queuePop) begin
                holdValid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mac_kbd_sequencer.sv
// Self-checking bench for mac_kbd_sequencer (INQ_TIMEOUT shortened to 100).
// A table of single commands is run first. Hand-written sequences follow for
// the inquiry key race, queue fill, busy drops, model flush, reset and slow cen.
module tb_mac_kbd_sequencer;

    logic       clk = 1'b0;
    logic       reset, cen, cmd_strobe, key_valid;
    logic [7:0] cmd_data, key_code;
    logic [7:0] resp_data;
    logic       resp_strobe, key_ready, busy, cmd_drop;

    int nCmp = 0, nFail = 0, div = 1, clkCnt = 0;

    mac_kbd_sequencer #(.RESP_DELAY(16), .INQ_TIMEOUT(100), .MODEL_ID(8'h0B), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .cen(cen), .cmd_data(cmd_data), .cmd_strobe(cmd_strobe),
        .resp_data(resp_data), .resp_strobe(resp_strobe), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .busy(busy), .cmd_drop(cmd_drop));

    always #5 clk = ~clk;
    always @(posedge clk) clkCnt <= clkCnt + 1;

    typedef struct {
        logic [7:0] cmd;
        bit         expStrobe;
        logic [7:0] expData;
        int         expLat;
    } vecT;

    task automatic chk(input string nm, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h (%0d) want 0x%0h (%0d)", nm, act, act, exp, exp);
        end
    endtask

    // One cen cycle; cen is high only on the last clk of the period.
    // The key source drops key_valid once its transfer is taken.
    task automatic tick();
        bit acc;
        for (int i = 0; i < div; i++) begin
            cen = (i == div - 1);
            acc = key_valid && key_ready && cen;
            @(posedge clk);
            #1;
            if (acc) key_valid = 1'b0;
        end
    endtask

    task automatic pushKey(input logic [7:0] k);
        key_code  = k;
        key_valid = 1'b1;
    endtask

    // Strobe one command and watch `limit` cen cycles after it.
    // Cycle 1 is the DECODE cycle.
    task automatic runCmd(input logic [7:0] cmd, input int limit, input int keyAt, input logic [7:0] keyVal,
                          input int dropAt, output int nStb, output int firstLat, output logic [7:0] firstData,
                          output logic [7:0] dataAt2, output int nDrop, output int busyLowFirst, output int clkLat);
        int start;
        nStb = 0; firstLat = -1; firstData = 8'h00; dataAt2 = 8'h00; nDrop = 0; busyLowFirst = -1; clkLat = -1;
        cmd_data = cmd; cmd_strobe = 1'b1;
        #1;
        if (cmd_drop) nDrop++;
        start = clkCnt;
        tick();
        cmd_strobe = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            if (resp_strobe) begin
                nStb++;
                if (nStb == 1) begin
                    firstLat = c; firstData = resp_data; clkLat = clkCnt - start;
                end
            end
            if (!busy && busyLowFirst < 0) busyLowFirst = c;
            if (c == 2) dataAt2 = resp_data;
            if (c == keyAt) pushKey(keyVal);
            if (c == dropAt) begin
                cmd_data = 8'h36; cmd_strobe = 1'b1;
            end
            #1;
            if (cmd_drop) nDrop++;
            tick();
            cmd_strobe = 1'b0;
        end
    endtask

    // Run one command and check it produces a single reply `exp` at cycle 18
    task automatic simpleReply(input string nm, input logic [7:0] cmd, input logic [7:0] exp);
        int nStb, lat, nDrop, blf, clkLat;
        logic [7:0] d, d2;
        runCmd(cmd, 25, -1, 8'h00, -1, nStb, lat, d, d2, nDrop, blf, clkLat);
        chk({nm, " strobes"}, nStb, 1);
        chk({nm, " data"}, d, exp);
    endtask

    vecT vecs[7];

    initial begin
        int nStb, lat, nDrop, blf, clkLat;
        logic [7:0] d, d2;
        logic [7:0] expQ[5];

        vecs[0] = '{8'h36, 1'b1, 8'h7D, 18};
        vecs[1] = '{8'h14, 1'b1, 8'h7B, 18};
        vecs[2] = '{8'h16, 1'b1, 8'h0B, 18};
        vecs[3] = '{8'hAA, 1'b0, 8'h00, 0};
        vecs[4] = '{8'h10, 1'b1, 8'h7B, 118};
        vecs[5] = '{8'h00, 1'b0, 8'h00, 0};
        vecs[6] = '{8'h15, 1'b0, 8'h00, 0};

        reset = 1'b1; cen = 1'b1; cmd_strobe = 1'b0; cmd_data = 8'h00; key_valid = 1'b0; key_code = 8'h00;
        tick(); tick();
        chk("reset busy", busy, 0);
        chk("reset resp_strobe", resp_strobe, 0);
        chk("reset cmd_drop", cmd_drop, 0);
        chk("reset key_ready", key_ready, 1);
        chk("reset resp_data", resp_data, 8'h00);
        reset = 1'b0;
        tick();

        // Table of single commands against an empty queue
        foreach (vecs[i]) begin
            runCmd(vecs[i].cmd, 130, -1, 8'h00, -1, nStb, lat, d, d2, nDrop, blf, clkLat);
            chk($sformatf("vec%0d strobes", i), nStb, vecs[i].expStrobe ? 1 : 0);
            chk($sformatf("vec%0d drops", i), nDrop, 0);
            if (vecs[i].expStrobe) begin
                chk($sformatf("vec%0d latency", i), lat, vecs[i].expLat);
                chk($sformatf("vec%0d data", i), d, vecs[i].expData);
                chk($sformatf("vec%0d busy end", i), blf, vecs[i].expLat + 1);
                if (vecs[i].expLat == 18) chk($sformatf("vec%0d data stable", i), d2, vecs[i].expData);
            end else begin
                chk($sformatf("vec%0d busy end", i), blf, 2);
            end
        end

        // Inquiry answered by a key arriving on cycle 50
        runCmd(8'h10, 130, 50, 8'h3E, -1, nStb, lat, d, d2, nDrop, blf, clkLat);
        chk("inq key strobes", nStb, 1);
        chk("inq key latency", lat, 68);
        chk("inq key data", d, 8'h3E);
        simpleReply("inq key queue empty", 8'h14, 8'h7B);

        // Queue fill and in-order drain
`ifdef KBD_SEQ_FIFO_EN
        for (int k = 1; k <= 5; k++) begin
            pushKey(8'(k));
            #1;
            chk($sformatf("fill key_ready %0d", k), key_ready, (k <= 4) ? 1 : 0);
            if (k <= 4) tick();
        end
        tick(); tick();
        chk("full held valid", key_valid, 1);
        chk("full key_ready", key_ready, 0);
        expQ = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        for (int i = 0; i < 5; i++) simpleReply($sformatf("drain%0d", i), 8'h14, expQ[i]);
        simpleReply("drain empty", 8'h14, 8'h7B);
`else
        pushKey(8'h01);
        #1;
        chk("fill key_ready 1", key_ready, 1);
        tick();
        pushKey(8'h02);
        #1;
        chk("fill key_ready 2", key_ready, 0);
        tick(); tick();
        chk("full held valid", key_valid, 1);
        expQ = '{8'h01, 8'h02, 8'h7B, 8'h7B, 8'h7B};
        for (int i = 0; i < 3; i++) simpleReply($sformatf("drain%0d", i), 8'h14, expQ[i]);
`endif

        // Command strobed while busy: in DELAY, and on the STROBE cycle
        runCmd(8'h14, 30, -1, 8'h00, 3, nStb, lat, d, d2, nDrop, blf, clkLat);
        chk("drop3 cmd_drop", nDrop, 1);
        chk("drop3 strobes", nStb, 1);
        chk("drop3 data", d, 8'h7B);
        runCmd(8'h36, 30, -1, 8'h00, 18, nStb, lat, d, d2, nDrop, blf, clkLat);
        chk("drop18 cmd_drop", nDrop, 1);
        chk("drop18 strobes", nStb, 1);
        chk("drop18 busy end", blf, 19);

        // Model flushes queued keys
        pushKey(8'h21);
        tick();
`ifdef KBD_SEQ_FIFO_EN
        pushKey(8'h22);
        tick();
`endif
        chk("flush pre valid", key_valid, 0);
        simpleReply("model", 8'h16, 8'h0B);
        simpleReply("after flush", 8'h14, 8'h7B);

        // Reset in DELAY with a key queued
        pushKey(8'h55);
        tick();
        cmd_data = 8'h36; cmd_strobe = 1'b1;
        tick();
        cmd_strobe = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset key_ready", key_ready, 1);
        chk("midreset resp_data", resp_data, 8'h00);
        tick();
        reset = 1'b0;
        nStb = 0;
        for (int i = 0; i < 50; i++) begin
            if (resp_strobe) nStb++;
            tick();
        end
        chk("midreset no strobe", nStb, 0);
        simpleReply("midreset queue lost", 8'h14, 8'h7B);

        // cen high 1 clk in 10: latency in cen cycles unchanged, in clks x10
        div = 10;
        runCmd(8'h36, 25, -1, 8'h00, -1, nStb, lat, d, d2, nDrop, blf, clkLat);
        chk("slow strobes", nStb, 1);
        chk("slow latency", lat, 18);
        chk("slow clk latency", clkLat, 180);
        chk("slow data", d, 8'h7D);
        div = 1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
